uart_bus_arbiter: RTL and testbench
===================================

# uart_bus_arbiter

Round-robin arbiter that shares the memory-mapped UART peripheral port of the system bus between several bus masters (CPU core load/store unit, debug/DMA engine). Each master presents a request; the arbiter grants one at a time, registers its address, data and direction, drives a single transaction into the UART module, and returns read data, a one-cycle ready pulse and an error flag. A timeout terminates any transaction the UART never accepts, so a master cannot hang the bus.

## Interface
Parameters:
- NUM_REQ, 2, number of masters (2..4)
- ADDR_WIDTH, `ADDR_WIDTH, bus address width
- DATA_WIDTH, `DATA_WIDTH, bus data width
- TIMEOUT, 255, maximum ISSUE cycles before abort (1..255, counter 8 bits)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- m_req_valid  in  NUM_REQ  per-master request, held until that master's m_ready
- m_addr  in  NUM_REQ*ADDR_WIDTH  per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wrt_data  in  NUM_REQ*DATA_WIDTH  per-master write data, same packing
- m_we  in  NUM_REQ  per-master write enable (1 write, 0 read)
- m_ready  out  NUM_REQ  one-cycle completion pulse to the granted master
- m_err  out  NUM_REQ  one-cycle timeout flag, coincident with m_ready
- m_rd_data  out  DATA_WIDTH  read data, valid when any m_ready bit is 1
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- s_addr  out  ADDR_WIDTH  to UART addr
- s_wrt_data  out  DATA_WIDTH  to UART wrt_data
- s_we  out  1  to UART we
- s_req_valid  out  1  to UART req_valid
- s_rd_data  in  DATA_WIDTH  from UART rd_data
- s_data_valid  in  1  from UART data_valid (accept/ready)

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any m_req_valid bit set, select winner by round-robin starting at (last_grant+1) mod NUM_REQ; capture winner's addr, wrt_data, we into holding registers; set grant one-hot; clear timeout counter; go ISSUE.
- ISSUE: s_req_valid=1, s_addr/s_wrt_data/s_we from holding registers. Accept = s_req_valid & (s_data_valid==1); X/Z on s_data_valid is not accept. On accept: capture s_rd_data (reads only; writes capture 0), go RESP. Else increment counter; when counter reaches TIMEOUT-1 without accept, set err, go RESP.
- RESP: m_ready[g]=1, m_err[g]=err, m_rd_data=captured data, update last_grant=g, clear grant, go IDLE.
- Exactly one accept cycle per transaction: s_req_valid is 0 in every state except ISSUE and drops the cycle after accept, so a UART write pushes the FIFO exactly once.
- Holding registers are fixed for the whole transaction; changes on m_* after capture are ignored.
- Master dropping m_req_valid after grant: transaction still completes, ready pulse still issued.
- Simultaneous requests: strict round-robin; a master that just completed has lowest priority next IDLE.
- Request arriving in ISSUE/RESP waits; no preemption.
- m_* outputs and s_* data outputs are 0 whenever not in the state defined above.

## Timing
- Reset (reset=0, async): state IDLE, last_grant=NUM_REQ-1 (master 0 wins first), grant=0, m_ready=0, m_err=0, m_rd_data=0, s_req_valid=0, s_we=0, s_addr=0, s_wrt_data=0, counter=0.
- Reset mid-transaction aborts immediately; no m_ready is ever issued for the aborted request.
- Latency: request sampled in cycle 0 (IDLE); s_req_valid high cycle 1; if s_data_valid=1 in cycle 1, m_ready in cycle 2; back in IDLE cycle 3. Minimum 3 cycles per transaction, back-to-back throughput one per 3 cycles.
- Accept in ISSUE cycle k (k>=1) gives m_ready in cycle k+1.
- Timeout: with s_data_valid stuck 0, s_req_valid stays high exactly TIMEOUT cycles, then m_ready+m_err in the following cycle.

## Test plan
- Single write: master 0 req, addr UART base, data 0x000000A5, we=1, s_data_valid=1 -> s_req_valid high exactly 1 cycle (cycle 1) with those values, m_ready[0] cycle 2, m_err=0.
- Read: master 1 req we=0, s_rd_data=0x12345678 -> m_rd_data=0x12345678 with m_ready[1], s_we=0 throughout.
- Contention: both masters request continuously -> grants alternate 0,1,0,1 over 4 transactions; no master starved.
- Backpressure/timeout: s_data_valid=0 for 5 cycles then 1 -> m_ready 6 cycles after s_req_valid rise, m_err=0; with s_data_valid held 0 and TIMEOUT=8 -> s_req_valid high 8 cycles, then m_ready[g]=m_err[g]=1.
- Field stability: change m_addr/m_wrt_data of granted master during ISSUE -> s_addr/s_wrt_data unchanged.
- Async reset during ISSUE -> all outputs 0 immediately, no m_ready; after release, master 0 wins first contention.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART peripheral port among NUM_REQ bus masters.
// One transaction at a time: IDLE picks a winner, ISSUE drives the UART, RESP answers the master.
module uart_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            m_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] m_wrt_data,
  input  logic [NUM_REQ-1:0]            m_we,
  output logic [NUM_REQ-1:0]            m_ready,
  output logic [NUM_REQ-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]         m_rd_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]         s_addr,
  output logic [DATA_WIDTH-1:0]         s_wrt_data,
  output logic                          s_we,
  output logic                          s_req_valid,
  input  logic [DATA_WIDTH-1:0]         s_rd_data,
  input  logic                          s_data_valid,
  output logic [1:0]                    dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          grant_idx;
  logic [ADDR_WIDTH-1:0]  hold_addr;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_we;
  logic [DATA_WIDTH-1:0]  rd_cap;
  logic                   err;
  logic [7:0]             cnt;

  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [IW-1:0]          pick;
  logic                   accept;
  logic                   timeout_hit;

  // Search starts just after the last owner, so the master that just finished ranks last.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    pick       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && m_req_valid[pick]) begin
        win_found        = 1'b1;
        win_idx          = pick;
        win_onehot       = '0;
        win_onehot[pick] = 1'b1;
      end
    end
  end

  // Handshake: the UART accepts when s_req_valid and s_data_valid are both 1 in the same
  // cycle; only a solid 1 counts, so an unknown s_data_valid keeps the request pending.
  always_comb begin
    accept = 1'b0;
    if (state == ISSUE && s_data_valid == 1'b1) accept = 1'b1;
  end

  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   if (accept || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(NUM_REQ - 1);
      grant_idx  <= '0;
      grant      <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_we    <= 1'b0;
      rd_cap     <= '0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            grant     <= win_onehot;
            hold_addr <= m_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            hold_data <= m_wrt_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            hold_we   <= m_we[win_idx];
            rd_cap    <= '0;
            err       <= 1'b0;
            cnt       <= '0;
          end
        end
        ISSUE: begin
          // Accept on the last allowed cycle still wins over the timeout.
          if (accept)           rd_cap <= hold_we ? '0 : s_rd_data;
          else if (timeout_hit) err    <= 1'b1;
          else                  cnt    <= cnt + 8'd1;
        end
        RESP: begin
          last_grant <= grant_idx;
          grant      <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_req_valid = (state == ISSUE);
    s_addr      = (state == ISSUE) ? hold_addr : '0;
    s_wrt_data  = (state == ISSUE) ? hold_data : '0;
    s_we        = (state == ISSUE) && hold_we;
    m_ready     = (state == RESP) ? grant : '0;
    m_err       = (state == RESP && err) ? grant : '0;
    m_rd_data   = (state == RESP) ? rd_cap : '0;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin / latency model.
module tb_uart_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_req_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wrt_data;
  logic [N-1:0]      m_we;
  logic [N-1:0]      m_ready;
  logic [N-1:0]      m_err;
  logic [DW-1:0]     m_rd_data;
  logic [N-1:0]      grant;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wrt_data;
  logic              s_we;
  logic              s_req_valid;
  logic [DW-1:0]     s_rd_data;
  logic              s_data_valid;
  logic [1:0]        dbg_state;

  logic [AW-1:0]     a_arr [N];
  logic [DW-1:0]     d_arr [N];
  logic              we_arr[N];
  logic [N-1:0]      req;

  int                checks = 0;
  int                errors = 0;
  int                model_last;
  logic [DW-1:0]     exp_q[$];

  always #5 clk = ~clk;

  uart_bus_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req_valid(m_req_valid), .m_addr(m_addr), .m_wrt_data(m_wrt_data), .m_we(m_we),
    .m_ready(m_ready), .m_err(m_err), .m_rd_data(m_rd_data), .grant(grant),
    .s_addr(s_addr), .s_wrt_data(s_wrt_data), .s_we(s_we), .s_req_valid(s_req_valid),
    .s_rd_data(s_rd_data), .s_data_valid(s_data_valid), .dbg_state(dbg_state)
  );

  always_comb begin
    m_addr     = '0;
    m_wrt_data = '0;
    m_we       = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]     = a_arr[i];
      m_wrt_data[i*DW +: DW] = d_arr[i];
      m_we[i]                = we_arr[i];
    end
  end
  assign m_req_valid = req;

  // Round-robin rule: first requester found going upward from the previous owner.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && r[(last + k) % N]) w = (last + k) % N;
    return w;
  endfunction

  // Plays the UART: accepts on ISSUE cycle delay+1 (delay<0 never accepts).
  task automatic wait_txn(input int exp_win, input int delay, input bit scramble,
                          input bit drop_early, output int lat);
    int            issue_n, exp_issue;
    bit            exp_err, done, prev_srv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, exp_rd;
    logic          ew;
    logic [N-1:0]  exp_grant, exp_errv;
    issue_n   = 0;
    done      = 0;
    prev_srv  = 0;
    lat       = 0;
    exp_err   = !(delay >= 0 && delay < TO);
    exp_issue = exp_err ? TO : delay + 1;
    exp_grant = '0;
    exp_grant[exp_win] = 1'b1;
    exp_errv  = exp_err ? exp_grant : '0;
    ea = a_arr[exp_win];
    ed = d_arr[exp_win];
    ew = we_arr[exp_win];
    if (ew) exp_q.push_back('0);
    else    exp_q.push_back(s_rd_data);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (s_req_valid) begin
        issue_n++;
        checks++;
        if (grant !== exp_grant || m_ready !== '0) begin
          errors++;
          $display("FAIL issue_grant: grant=%b m_ready=%b required grant=%b m_ready=00",
                   grant, m_ready, exp_grant);
        end
        checks++;
        if (s_addr !== ea || s_wrt_data !== ed || s_we !== ew) begin
          errors++;
          $display("FAIL issue_fields: addr=%h data=%h we=%b required %h %h %b",
                   s_addr, s_wrt_data, s_we, ea, ed, ew);
        end
        s_data_valid = (delay >= 0 && issue_n > delay);
        if (scramble) begin
          a_arr[exp_win]  = $urandom;
          d_arr[exp_win]  = $urandom;
          we_arr[exp_win] = ~we_arr[exp_win];
        end
        if (drop_early) req[exp_win] = 1'b0;
        prev_srv = 1;
      end else if (|m_ready) begin
        done = 1;
        s_data_valid = 1'b0;
        exp_rd = exp_q.pop_front();
        checks++;
        if (m_ready !== exp_grant) begin
          errors++;
          $display("FAIL ready_owner: m_ready=%b required %b", m_ready, exp_grant);
        end
        checks++;
        if (m_err !== exp_errv) begin
          errors++;
          $display("FAIL err_flag: m_err=%b required %b", m_err, exp_errv);
        end
        checks++;
        if (issue_n != exp_issue || !prev_srv) begin
          errors++;
          $display("FAIL issue_len: s_req_valid cycles=%0d contiguous=%0b required %0d,1",
                   issue_n, prev_srv, exp_issue);
        end
        if (!exp_err) begin
          checks++;
          if (m_rd_data !== exp_rd) begin
            errors++;
            $display("FAIL rd_data: m_rd_data=%h required %h", m_rd_data, exp_rd);
          end
        end
        req[exp_win] = 1'b0;
        model_last = exp_win;
      end else begin
        s_data_valid = 1'b0;
        prev_srv = 0;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout: no m_ready within 40 cycles for master %0d", exp_win);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0;
    s_data_valid = 1'b0;
    s_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; d_arr[i] = '0; we_arr[i] = 1'b0;
    end
    model_last = N - 1;
    #12;
    checks++;
    if ({grant, m_ready, m_err, m_rd_data, s_req_valid, s_we, s_addr, s_wrt_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b ready=%b err=%b rd=%h srv=%b we=%b addr=%h wd=%h required all 0",
               grant, m_ready, m_err, m_rd_data, s_req_valid, s_we, s_addr, s_wrt_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int lat;
    @(negedge clk);
    a_arr[0] = 32'h0000_1000; d_arr[0] = 32'h0000_00A5; we_arr[0] = 1'b1;
    s_rd_data = 32'hDEAD_BEEF;
    req[0] = 1'b1;
    wait_txn(rr_pick(req, model_last), 0, 0, 0, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL write_latency: m_ready cycle=%0d required 2", lat);
    end
    @(negedge clk);
    checks++;
    if (grant !== '0 || m_ready !== '0 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: grant=%b ready=%b srv=%b required 0", grant, m_ready, s_req_valid);
    end
  endtask

  task automatic test_read();
    int lat;
    @(negedge clk);
    a_arr[1] = 32'h0000_1004; d_arr[1] = 32'hFFFF_0000; we_arr[1] = 1'b0;
    s_rd_data = 32'h1234_5678;
    req[1] = 1'b1;
    wait_txn(rr_pick(req, model_last), 2, 0, 1, lat);
  endtask

  task automatic test_contention();
    int lat, w;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 32'h2000 + i; d_arr[i] = $urandom; we_arr[i] = i[0];
    end
    req = '1;
    for (int t = 0; t < 4; t++) begin
      s_rd_data = $urandom;
      w = rr_pick(req, model_last);
      wait_txn(w, 0, 0, 0, lat);
      checks++;
      if (lat != ((t == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL contention_rate: txn %0d took %0d cycles required %0d", t, lat, (t == 0) ? 2 : 3);
      end
      req[w] = 1'b1;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure_timeout();
    int lat;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    a_arr[0] = 32'h3000; d_arr[0] = 32'h55; we_arr[0] = 1'b0;
    s_rd_data = 32'hCAFE_0001;
    req[0] = 1'b1;
    wait_txn(rr_pick(req, model_last), 5, 0, 0, lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL backpressure_latency: m_ready cycle=%0d required 7", lat);
    end
    @(negedge clk);
    req[1] = 1'b1;
    a_arr[1] = 32'h3004; d_arr[1] = 32'h77; we_arr[1] = 1'b1;
    wait_txn(rr_pick(req, model_last), -1, 0, 0, lat);
    checks++;
    if (lat != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: m_ready cycle=%0d required %0d", lat, TO + 1);
    end
  endtask

  task automatic test_field_stability();
    int lat;
    @(negedge clk);
    a_arr[0] = 32'h4000; d_arr[0] = 32'h1111_2222; we_arr[0] = 1'b1;
    a_arr[1] = 32'h4004; d_arr[1] = 32'h3333_4444; we_arr[1] = 1'b0;
    s_rd_data = 32'h0BAD_F00D;
    req = '1;
    wait_txn(rr_pick(req, model_last), 3, 1, 0, lat);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    a_arr[1] = 32'h5000; d_arr[1] = 32'h99; we_arr[1] = 1'b1;
    req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_issue: s_req_valid=%b required 1", s_req_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({grant, m_ready, m_err, m_rd_data, s_req_valid, s_we, s_addr, s_wrt_data} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: grant=%b ready=%b srv=%b addr=%h required all 0",
               grant, m_ready, s_req_valid, s_addr);
    end
    s_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_ready !== '0 || s_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: m_ready=%b srv=%b required 0", m_ready, s_req_valid);
      end
    end
    s_data_valid = 1'b0;
    model_last = N - 1;
    exp_q.delete();
    a_arr[0] = 32'h5100; d_arr[0] = 32'h42; we_arr[0] = 1'b0;
    s_rd_data = 32'h0000_5A5A;
    req = '1;
    reset = 1'b1;
    wait_txn(rr_pick(req, model_last), 0, 0, 0, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL post_reset_latency: m_ready cycle=%0d required 2", lat);
    end
  endtask

  task automatic test_random();
    int lat, delay;
    logic [N-1:0] add;
    for (int t = 0; t < 24; t++) begin
      add = N'($urandom) & ~req;
      if ((req | add) == '0) add[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (add[i]) begin
          a_arr[i]  = $urandom;
          d_arr[i]  = $urandom;
          we_arr[i] = 1'($urandom_range(0, 1));
        end
      end
      req = req | add;
      s_rd_data = $urandom;
      delay = $urandom_range(0, 9);
      if (delay == 9) delay = -1;
      wait_txn(rr_pick(req, model_last), delay, 0, 0, lat);
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_backpressure_timeout();
    test_field_stability();
    test_async_reset();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
